// File: rtl/scan_pkg.sv
// Shared types and constants for the scan/transfer controller and its drain timer.
package scan_pkg;

  localparam int BUF_DEPTH_DEF   = 10;
  localparam int DRAIN_TICKS_DEF = 8;
  localparam int UNIT_W          = 4;

  // Occupancy captured when a transfer is triggered by the 90% flag.
  localparam logic [UNIT_W-1:0] OCC_LEVEL90 = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCANNING  = 3'd1,
    ST_WAIT_XFER = 3'd2,
    ST_HALT      = 3'd3,
    ST_TRANSFER  = 3'd4
  } scan_state_e;

endpackage

// File: rtl/drain_timer.sv
// Free-running tick divider: counts 0..DRAIN_TICKS-1 while enabled and flags the wrap cycle.
module drain_timer
  import scan_pkg::*;
#(
  parameter int DRAIN_TICKS = DRAIN_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DRAIN_TICKS > 1) ? $clog2(DRAIN_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CNT_LAST);

  // Next count: clear wins over counting, wrap back to zero on the tick cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_transfer_ctrl.sv
// Scan session controller: arbitrates the shared transmit channel against a peer
// scanner and drains the buffer one unit per DRAIN_TICKS cycles.
module scan_transfer_ctrl
  import scan_pkg::*;
#(
  parameter int DRAIN_TICKS = DRAIN_TICKS_DEF,
  parameter int BUF_DEPTH   = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startScan,
  input  logic              level80,
  input  logic              level90,
  input  logic              level100,
  input  logic              peerTransferring,
  output logic              beginScanning,
  output logic              warn80,
  output logic              stopped,
  output logic              transferring,
  output logic              drainPulse,
  output logic [UNIT_W-1:0] unitsSent,
  output logic              xferDone
);

  localparam logic [UNIT_W-1:0] OCC_FULL = UNIT_W'(BUF_DEPTH);
  localparam logic [UNIT_W-1:0] UNIT_ONE = 4'd1;

  scan_state_e       state_q, state_d;
  logic [UNIT_W-1:0] occ_q, occ_d;
  logic [UNIT_W-1:0] units_q, units_d;
  logic              begin_q, begin_d, warn_q, warn_d, stop_q, stop_d;
  logic              xfer_q, xfer_d, drain_q, drain_d, done_q, done_d;
  logic              tick_s, last_unit_s, timer_en_s, timer_clr_s;

  // Timer sits at zero outside TRANSFER, so every transfer starts from a fresh count.
  assign timer_en_s  = (state_q == ST_TRANSFER);
  assign timer_clr_s = !timer_en_s;
  assign last_unit_s = tick_s && ((units_q + UNIT_ONE) == occ_q);

  drain_timer #(.DRAIN_TICKS(DRAIN_TICKS)) u_drain_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (timer_en_s),
    .clear  (timer_clr_s),
    .tick   (tick_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and captured occupancy; level flags only matter in SCANNING/WAIT_XFER.
  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    case (state_q)
      ST_IDLE: begin
        if (startScan) state_d = ST_SCANNING;
        else           state_d = ST_IDLE;
      end
      ST_SCANNING: begin
        if (level100) begin
          if (peerTransferring) state_d = ST_HALT;
          else begin state_d = ST_TRANSFER; occ_d = OCC_FULL; end
        end else if (level90) begin
          if (peerTransferring) state_d = ST_WAIT_XFER;
          else begin state_d = ST_TRANSFER; occ_d = OCC_LEVEL90; end
        end else begin
          state_d = ST_SCANNING;
        end
      end
      ST_WAIT_XFER: begin
        if (level100) begin
          if (peerTransferring) state_d = ST_HALT;
          else begin state_d = ST_TRANSFER; occ_d = OCC_FULL; end
        end else if (!peerTransferring) begin
          state_d = ST_TRANSFER;
          occ_d   = OCC_LEVEL90;
        end else begin
          state_d = ST_WAIT_XFER;
        end
      end
      ST_HALT: begin
        if (!peerTransferring) begin state_d = ST_TRANSFER; occ_d = OCC_FULL; end
        else                   state_d = ST_HALT;
      end
      ST_TRANSFER: begin
        if (last_unit_s) state_d = ST_IDLE;
        else             state_d = ST_TRANSFER;
      end
      default: begin
        state_d = ST_IDLE;
        occ_d   = '0;
      end
    endcase
  end

  // Output next values; outputs are registered so they line up with the state they describe.
  always_comb begin
    begin_d = (state_q == ST_IDLE) && startScan;
    stop_d  = (state_d == ST_HALT);
    xfer_d  = (state_d == ST_TRANSFER);
    drain_d = tick_s;
    done_d  = last_unit_s;
    if (state_d == ST_IDLE) begin
      warn_d = 1'b0;
    end else if ((state_q == ST_SCANNING) && level80 && !level90 && !level100) begin
      warn_d = 1'b1;
    end else begin
      warn_d = warn_q;
    end
    if (xfer_d && (state_q != ST_TRANSFER)) begin
      units_d = '0;
    end else if (tick_s) begin
      units_d = units_q + UNIT_ONE;
    end else begin
      units_d = units_q;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q   <= '0;
      units_q <= '0;
      begin_q <= 1'b0;
      warn_q  <= 1'b0;
      stop_q  <= 1'b0;
      xfer_q  <= 1'b0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      units_q <= units_d;
      begin_q <= begin_d;
      warn_q  <= warn_d;
      stop_q  <= stop_d;
      xfer_q  <= xfer_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  assign beginScanning = begin_q;
  assign warn80        = warn_q;
  assign stopped       = stop_q;
  assign transferring  = xfer_q;
  assign drainPulse    = drain_q;
  assign unitsSent     = units_q;
  assign xferDone      = done_q;

endmodule

// File: tb/tb_scan_transfer_ctrl.sv
// Directed bench for scan_transfer_ctrl with default parameters (8 ticks/unit, depth 10).
module tb_scan_transfer_ctrl;
  import scan_pkg::*;

  logic       clk, reset, startScan, level80, level90, level100, peerTransferring;
  logic       beginScanning, warn80, stopped, transferring, drainPulse, xferDone;
  logic [3:0] unitsSent;

  int n_checks = 0;
  int n_errors = 0;

  scan_transfer_ctrl dut (
    .clk(clk), .reset(reset), .startScan(startScan),
    .level80(level80), .level90(level90), .level100(level100),
    .peerTransferring(peerTransferring),
    .beginScanning(beginScanning), .warn80(warn80), .stopped(stopped),
    .transferring(transferring), .drainPulse(drainPulse),
    .unitsSent(unitsSent), .xferDone(xferDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, beginScanning, warn80, stopped, transferring, drainPulse, xferDone, unitsSent};
  endfunction

  task automatic start_scan();
    startScan = 1'b1;
    @(negedge clk);
    startScan = 1'b0;
  endtask

  task automatic pulse_levels(input logic l80, input logic l90, input logic l100);
    level80 = l80; level90 = l90; level100 = l100;
    @(negedge clk);
    level80 = 1'b0; level90 = 1'b0; level100 = 1'b0;
  endtask

  // Called on the first negedge inside TRANSFER; cycle c counts negedges after entry.
  task automatic run_xfer(input bit inject, output int np, output int first, output int done_c,
                          output int badsp, output int nbeg, output int units_done);
    np = 0; first = -1; done_c = -1; badsp = 0; nbeg = 0; units_done = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (inject) begin
        if (c == 3) startScan = 1'b1;
        else if (c == 4) startScan = 1'b0;
        if (c == 20) peerTransferring = 1'b1;
      end
      if (beginScanning) nbeg++;
      if (drainPulse) begin
        np++;
        if (first < 0) first = c;
        if (c % 8 != 0) badsp++;
      end
      if (xferDone) begin
        done_c = c;
        units_done = int'(unitsSent);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int np, first, done_c, badsp, nbeg, ud;
    bit seen4;
    reset = 1'b0; startScan = 1'b0; level80 = 1'b0; level90 = 1'b0; level100 = 1'b0;
    peerTransferring = 1'b0;

    // Reset state, then a level flag in IDLE must not move the FSM.
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 32'd0);
    chk("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b1;
    pulse_levels(1'b0, 1'b1, 1'b0);
    chk("idle_ignores_level", 32'(dut.state_q), 32'(ST_IDLE));

    // Scenario 1: start pulse.
    start_scan();
    chk("s1_begin", 32'(beginScanning), 32'd1);
    chk("s1_state", 32'(dut.state_q), 32'(ST_SCANNING));
    @(negedge clk);
    chk("s1_begin_1cyc", 32'(beginScanning), 32'd0);

    // Scenario 2: 80% then 90% with free channel -> 9 units.
    pulse_levels(1'b1, 1'b0, 1'b0);
    chk("s2_warn80", 32'(warn80), 32'd1);
    chk("s2_still_scan", 32'(dut.state_q), 32'(ST_SCANNING));
    pulse_levels(1'b0, 1'b1, 1'b0);
    chk("s2_xfer", 32'(transferring), 32'd1);
    chk("s2_warn_held", 32'(warn80), 32'd1);
    run_xfer(1'b0, np, first, done_c, badsp, nbeg, ud);
    chk("s2_npulse", 32'(np), 32'd9);
    chk("s2_first", 32'(first), 32'd8);
    chk("s2_spacing", 32'(badsp), 32'd0);
    chk("s2_done_cyc", 32'(done_c), 32'd72);
    chk("s2_units", 32'(ud), 32'd9);
    chk("s2_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("s2_warn_clr", 32'(warn80), 32'd0);
    repeat (3) @(negedge clk);
    chk("s2_units_hold", 32'(unitsSent), 32'd9);

    // Scenario 3: peer busy -> WAIT_XFER, 100% -> HALT, peer drops -> 10 units.
    start_scan();
    peerTransferring = 1'b1;
    pulse_levels(1'b0, 1'b1, 1'b0);
    chk("s3_wait", 32'(dut.state_q), 32'(ST_WAIT_XFER));
    chk("s3_wait_noxfer", 32'(transferring), 32'd0);
    pulse_levels(1'b0, 1'b0, 1'b1);
    chk("s3_stopped", 32'(stopped), 32'd1);
    chk("s3_halt", 32'(dut.state_q), 32'(ST_HALT));
    repeat (4) @(negedge clk);
    chk("s3_stopped_held", 32'(stopped), 32'd1);
    peerTransferring = 1'b0;
    @(negedge clk);
    chk("s3_xfer", 32'(transferring), 32'd1);
    chk("s3_stopped_clr", 32'(stopped), 32'd0);
    chk("s3_units_clr", 32'(unitsSent), 32'd0);
    run_xfer(1'b0, np, first, done_c, badsp, nbeg, ud);
    chk("s3_npulse", 32'(np), 32'd10);
    chk("s3_done_cyc", 32'(done_c), 32'd80);
    chk("s3_units", 32'(ud), 32'd10);

    // Scenario 4: 90% and 100% together -> full occupancy.
    start_scan();
    pulse_levels(1'b0, 1'b1, 1'b1);
    chk("s4_xfer", 32'(transferring), 32'd1);
    run_xfer(1'b0, np, first, done_c, badsp, nbeg, ud);
    chk("s4_npulse", 32'(np), 32'd10);
    chk("s4_done_cyc", 32'(done_c), 32'd80);

    // Scenario 5: async reset after the 4th drain pulse.
    start_scan();
    pulse_levels(1'b0, 1'b1, 1'b0);
    np = 0; seen4 = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (drainPulse) np++;
      if (np == 4) begin seen4 = 1'b1; break; end
    end
    chk("s5_reach4", 32'(seen4), 32'd1);
    chk("s5_units4", 32'(unitsSent), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("s5_rst_outs", outs(), 32'd0);
    chk("s5_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("s5_post_idle", 32'(dut.state_q), 32'(ST_IDLE));
    start_scan();
    chk("s5_restart_begin", 32'(beginScanning), 32'd1);
    chk("s5_restart_state", 32'(dut.state_q), 32'(ST_SCANNING));

    // Scenario 6: startScan and peer rise during TRANSFER are ignored.
    pulse_levels(1'b0, 1'b1, 1'b0);
    chk("s6_xfer", 32'(transferring), 32'd1);
    run_xfer(1'b1, np, first, done_c, badsp, nbeg, ud);
    chk("s6_nbegin", 32'(nbeg), 32'd0);
    chk("s6_npulse", 32'(np), 32'd9);
    chk("s6_done_cyc", 32'(done_c), 32'd72);
    chk("s6_units", 32'(ud), 32'd9);
    peerTransferring = 1'b0;
    @(negedge clk);
    chk("s6_idle", 32'(dut.state_q), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
